// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI flash frame reader.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BANK = 3'd1,
        ST_CMD       = 3'd2,
        ST_ADDR      = 3'd3,
        ST_DATA      = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam int         CMD_BITS  = 8;
    localparam int         ADDR_BITS = 24;
    localparam int         CS_GAP    = 4;

    // Flash byte address of a frame; wraps modulo 2^24.
    function automatic logic [23:0] frame_addr(input logic [23:0] base,
                                               input logic [12:0] idx,
                                               input int unsigned frame_bytes);
        logic [31:0] sum;
        sum = {8'd0, base} + ({19'd0, idx} * frame_bytes);
        return sum[23:0];
    endfunction

    function automatic logic is_spi_active(input state_t s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: each SPI_clk level lasts CLK_DIV cycles while enabled,
// with registered rise/fall strobes aligned to the first cycle of the new level.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK_40,
    input  logic reset,
    input  logic en,
    output logic SPI_clk,
    output logic rise,
    output logic fall
);

    localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_reg;
    logic          sclk_reg;
    logic          rise_reg;
    logic          fall_reg;

    // Dropping en parks the clock low and restarts the divider phase.
    always_ff @(posedge CLK_40) begin
        if (reset || !en) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_reg <= '0;
                sclk_reg    <= !sclk_reg;
                rise_reg    <= !sclk_reg;
                fall_reg    <= sclk_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

    assign SPI_clk = sclk_reg;
    assign rise    = rise_reg;
    assign fall    = fall_reg;

endmodule

// File: rtl/spi_frame_reader.sv
// Streams 1-bit-per-pixel frames from SPI flash (READ 0x03) into the video banks.
// Define SPI_FRAME_LOOP_EN to wrap back to frame 0 forever instead of stopping.
module spi_frame_reader
    import spi_frame_pkg::*;
#(
    parameter int          CLK_DIV    = 2,
    parameter int          FRAME_BITS = 30000,
    parameter int          NUM_FRAMES = 6572,
    parameter logic [23:0] BASE_ADDR  = 24'h000000
) (
    input  logic        CLK_40,
    input  logic        reset,
    input  logic        start,
    input  logic        bank_full,
    input  logic        MISO,
    output logic        SPI_clk,
    output logic        SPI_CS_N,
    output logic        MOSI,
    output logic        SPI_clk_en,
    output logic        video_bank_we,
    output logic        frame_done,
    output logic        busy,
    output logic [12:0] frame_idx
);

    localparam int             FRAME_BYTES = FRAME_BITS / 8;
    localparam int             DW          = $clog2(FRAME_BITS + 1);
    localparam logic [DW-1:0]  DATA_LAST   = DW'(FRAME_BITS - 1);
    localparam logic [4:0]     CMD_LAST    = 5'(CMD_BITS - 1);
    localparam logic [4:0]     ADDR_LAST   = 5'(ADDR_BITS - 1);
    localparam logic [2:0]     GAP_LAST    = 3'(CS_GAP - 1);
    localparam logic [12:0]    LAST_FRAME  = 13'(NUM_FRAMES - 1);

`ifdef SPI_FRAME_LOOP_EN
    localparam state_t LAST_FRAME_NEXT = ST_WAIT_BANK;
`else
    localparam state_t LAST_FRAME_NEXT = ST_IDLE;
`endif

    state_t         state_reg;
    state_t         state_next;
    logic [4:0]     bit_cnt_reg;
    logic [DW-1:0]  data_cnt_reg;
    logic [2:0]     gap_cnt_reg;
    logic [12:0]    frame_idx_reg;
    logic [31:0]    shift_reg;
    logic           cs_n_reg;
    logic           frame_done_reg;
    logic           sclk_rise;
    logic           sclk_fall;
    logic           gen_en;

    // Pixel data goes straight from MISO to the banks; this block only times the write.
    logic unused_miso;
    assign unused_miso = MISO;

    // Stop the clock in the same edge that leaves the SPI states, so it never runs into GAP.
    assign gen_en = is_spi_active(state_reg) && is_spi_active(state_next);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .CLK_40  (CLK_40),
        .reset   (reset),
        .en      (gen_en),
        .SPI_clk (SPI_clk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (start) state_next = ST_WAIT_BANK;
            ST_WAIT_BANK: if (!bank_full) state_next = ST_CMD;
            ST_CMD:       if (sclk_fall && bit_cnt_reg == CMD_LAST) state_next = ST_ADDR;
            ST_ADDR:      if (sclk_fall && bit_cnt_reg == ADDR_LAST) state_next = ST_DATA;
            ST_DATA:      if (sclk_rise && data_cnt_reg == DATA_LAST) state_next = ST_GAP;
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST)
                    state_next = (frame_idx_reg == LAST_FRAME) ? LAST_FRAME_NEXT : ST_WAIT_BANK;
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            data_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            frame_idx_reg  <= '0;
            shift_reg      <= '0;
            cs_n_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_WAIT_BANK: begin
                    if (!bank_full) begin
                        cs_n_reg    <= 1'b0;
                        bit_cnt_reg <= '0;
                        shift_reg   <= {CMD_READ, frame_addr(BASE_ADDR, frame_idx_reg, FRAME_BYTES)};
                    end
                end
                ST_CMD, ST_ADDR: begin
                    if (sclk_fall) begin
                        shift_reg   <= {shift_reg[30:0], 1'b0};
                        bit_cnt_reg <= (state_next != state_reg) ? 5'd0 : bit_cnt_reg + 5'd1;
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        if (data_cnt_reg == DATA_LAST) begin
                            data_cnt_reg   <= '0;
                            cs_n_reg       <= 1'b1;
                            frame_done_reg <= 1'b1;
                        end else begin
                            data_cnt_reg <= data_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg   <= '0;
                        frame_idx_reg <= (frame_idx_reg == LAST_FRAME) ? 13'd0 : frame_idx_reg + 13'd1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SPI_CS_N      = cs_n_reg;
    assign MOSI          = shift_reg[31];
    assign SPI_clk_en    = sclk_rise && (state_reg == ST_DATA);
    assign video_bank_we = SPI_clk_en;
    assign frame_done    = frame_done_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign frame_idx     = frame_idx_reg;

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader with a small flash model (short frames, 2 frames).
module tb_spi_frame_reader;

    localparam int          CLK_DIV    = 2;
    localparam int          FRAME_BITS = 96;
    localparam int          NUM_FRAMES = 2;
    localparam logic [23:0] BASE_ADDR  = 24'hFFFFF4;
    // Frame 0 at 0xFFFFF4; frame 1 at 0xFFFFF4 + 12 which wraps to 0x000000.
    localparam logic [23:0] ADDR_F0    = 24'hFFFFF4;
    localparam logic [23:0] ADDR_F1    = 24'h000000;
    // CS falls, 32 command/address clocks of 4 cycles, then 2 cycles to the 33rd rise.
    localparam int          FIRST_DELAY = 130;

    logic        CLK_40 = 1'b0;
    logic        reset, start, bank_full, MISO;
    logic        SPI_clk, SPI_CS_N, MOSI, SPI_clk_en, video_bank_we, frame_done, busy;
    logic [12:0] frame_idx;

    int tests = 0;
    int fails = 0;

    spi_frame_reader #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS),
        .NUM_FRAMES (NUM_FRAMES),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .CLK_40        (CLK_40),
        .reset         (reset),
        .start         (start),
        .bank_full     (bank_full),
        .MISO          (MISO),
        .SPI_clk       (SPI_clk),
        .SPI_CS_N      (SPI_CS_N),
        .MOSI          (MOSI),
        .SPI_clk_en    (SPI_clk_en),
        .video_bank_we (video_bank_we),
        .frame_done    (frame_done),
        .busy          (busy),
        .frame_idx     (frame_idx)
    );

    always #5 CLK_40 = ~CLK_40;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic pattern(input int i);
        return i[0] ^ i[3];   // checkerboard with rows of 8 pixels
    endfunction

    task automatic tick();
        @(negedge CLK_40);
        #1;
    endtask

    // Flash model: shifts in command+address on SPI_clk rises, then shifts data out on falls.
    int          rx_cnt = 0;
    int          tx_idx = 0;
    logic [31:0] rx_word = '0;
    logic [7:0]  last_cmd = '0;
    logic [23:0] last_addr = '0;
    logic        prev_sclk = 1'b0;

    always @(posedge CLK_40) begin
        if (SPI_CS_N || reset) begin
            rx_cnt = 0;
            tx_idx = 0;
        end else if (SPI_clk && !prev_sclk && rx_cnt < 32) begin
            rx_word = {rx_word[30:0], MOSI};
            rx_cnt++;
            if (rx_cnt == 32) begin
                last_cmd  = rx_word[31:24];
                last_addr = rx_word[23:0];
            end
        end else if (!SPI_clk && prev_sclk && rx_cnt == 32) begin
            MISO <= pattern(tx_idx);
            tx_idx++;
        end
        prev_sclk = SPI_clk;
    end

    // Strobe monitor.
    int   cyc = 0;
    int   cs_fall_cyc = 0;
    int   first_delay = 0;
    int   frame_strobes = 0;
    int   total_strobes = 0;
    int   last_frame_strobes = 0;
    int   frame_done_cnt = 0;
    int   we_err = 0;
    logic prev_cs_n = 1'b1;

    always @(negedge CLK_40) begin
        cyc++;
        if (prev_cs_n && !SPI_CS_N) cs_fall_cyc = cyc;
        prev_cs_n = SPI_CS_N;
        if (video_bank_we !== SPI_clk_en) we_err++;
        if (SPI_clk_en) begin
            if (frame_strobes == 0) first_delay = cyc - cs_fall_cyc;
            check("miso_at_strobe", MISO, pattern(frame_strobes));
            frame_strobes++;
            total_strobes++;
        end
        if (frame_done) begin
            last_frame_strobes = frame_strobes;
            frame_strobes = 0;
            frame_done_cnt++;
        end
    end

    task automatic wait_frame_done(input string tag);
        for (int i = 0; i < 1500 && !frame_done; i++) tick();
        check(tag, frame_done, 1'b1);
    endtask

    initial begin
        int snap;
        int sclk_edges;
        int cs_low_cycles;
        logic last_sclk;

        reset = 1'b1; start = 1'b0; bank_full = 1'b0; MISO = 1'b0;
        repeat (3) tick();
        check("rst_cs_n", SPI_CS_N, 1'b1);
        check("rst_sclk", SPI_clk, 1'b0);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_clk_en", SPI_clk_en, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_idx", frame_idx, 13'd0);
        reset = 1'b0;
        tick();

        // Frame 0: start, then a stray start in DATA and bank_full rising mid-frame.
        start = 1'b1; tick(); start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        for (int i = 0; i < 20 && SPI_CS_N; i++) tick();
        check("cs_fall_f0", SPI_CS_N, 1'b0);
        for (int i = 0; i < 600 && frame_strobes < 10; i++) tick();
        check("reach_data_f0", frame_strobes, 10);
        start = 1'b1; tick(); start = 1'b0;
        bank_full = 1'b1;
        wait_frame_done("frame_done_f0");
        $display("[TB] frame 0: cmd=0x%0h addr=0x%0h strobes=%0d delay=%0d",
                 last_cmd, last_addr, last_frame_strobes, first_delay);
        check("cmd_f0", last_cmd, 8'h03);
        check("addr_f0", last_addr, ADDR_F0);
        check("strobes_f0", last_frame_strobes, FRAME_BITS);
        check("first_delay_f0", first_delay, FIRST_DELAY);
        check("idx_at_done_f0", frame_idx, 13'd0);
        for (int i = 0; i < 4; i++) begin
            check("gap_cs_n", SPI_CS_N, 1'b1);
            check("gap_sclk", SPI_clk, 1'b0);
            tick();
        end

        // Hold bank_full: no clock activity, CS high, waiting on frame 1.
        sclk_edges = 0;
        cs_low_cycles = 0;
        last_sclk = SPI_clk;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (SPI_clk !== last_sclk) sclk_edges++;
            if (!SPI_CS_N) cs_low_cycles++;
            last_sclk = SPI_clk;
        end
        check("hold_sclk_edges", sclk_edges, 0);
        check("hold_cs_low", cs_low_cycles, 0);
        check("hold_busy", busy, 1'b1);
        check("hold_frame_idx", frame_idx, 13'd1);
        bank_full = 1'b0;

        // Frame 1 (last frame): address wraps to zero.
        for (int i = 0; i < 20 && SPI_CS_N; i++) tick();
        check("cs_fall_f1", SPI_CS_N, 1'b0);
        wait_frame_done("frame_done_f1");
        $display("[TB] frame 1: cmd=0x%0h addr=0x%0h strobes=%0d", last_cmd, last_addr, last_frame_strobes);
        check("addr_f1", last_addr, ADDR_F1);
        check("strobes_f1", last_frame_strobes, FRAME_BITS);
        check("first_delay_f1", first_delay, FIRST_DELAY);
        repeat (10) tick();
        check("idx_after_last", frame_idx, 13'd0);
`ifdef SPI_FRAME_LOOP_EN
        check("loop_busy", busy, 1'b1);
        wait_frame_done("frame_done_loop");
        $display("[TB] loop frame: addr=0x%0h strobes=%0d", last_addr, last_frame_strobes);
        check("addr_loop", last_addr, ADDR_F0);
        check("strobes_loop", last_frame_strobes, FRAME_BITS);
`else
        check("stop_busy", busy, 1'b0);
        check("stop_cs_n", SPI_CS_N, 1'b1);
        snap = total_strobes;
        repeat (50) tick();
        check("stop_no_strobes", total_strobes, snap);
        start = 1'b1; tick(); start = 1'b0;
`endif

        // Reset in the middle of frame 1, together with start.
        for (int i = 0; i < 3000 && !(frame_idx == 13'd1 && frame_strobes == 40); i++) tick();
        check("reach_mid_f1", frame_strobes, 40);
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        $display("[TB] mid-frame reset: cs_n=%0b sclk=%0b idx=%0d busy=%0b", SPI_CS_N, SPI_clk, frame_idx, busy);
        check("mrst_cs_n", SPI_CS_N, 1'b1);
        check("mrst_sclk", SPI_clk, 1'b0);
        check("mrst_frame_idx", frame_idx, 13'd0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_clk_en", SPI_clk_en, 1'b0);
        frame_strobes = 0;
        snap = total_strobes;
        repeat (200) tick();
        check("mrst_no_strobes", total_strobes, snap);
        check("mrst_idle", busy, 1'b0);
        check("frame_done_total", frame_done_cnt, 3);
        check("we_eq_clk_en", we_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_frame_reader.md
SPI_FRAME_READER -- requirements
Module: spi_frame_reader

Interface
REQ-001 Parameter CLK_DIV, default 2: CLK_40 cycles per SPI_clk half-period (>=1).
REQ-002 Parameter FRAME_BITS, default 30000: 200x150 one-bit pixels per frame.
REQ-003 Parameter NUM_FRAMES, default 6572: number of frames stored in flash.
REQ-004 Parameter BASE_ADDR, default 24'h000000: flash byte address of frame 0.
REQ-005 CLK_40  input  1: the only clock. All logic uses its rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 start  input  1: one-cycle pulse that starts streaming from IDLE.
REQ-008 bank_full  input  1: high while no video bank can accept a new frame.
REQ-009 MISO  input  1: serial data from the flash.
REQ-010 SPI_clk  output  1: SPI clock, mode 0, idles low, registered.
REQ-011 SPI_CS_N  output  1: flash chip select, active low, registered.
REQ-012 MOSI  output  1: command and address bits, MSB first, registered.
REQ-013 SPI_clk_en  output  1: one-cycle strobe for each valid pixel bit on MISO.
REQ-014 video_bank_we  output  1: write enable to the video banks, identical to SPI_clk_en.
REQ-015 frame_done  output  1: one-cycle pulse after the last bit of each frame.
REQ-016 busy  output  1: high in every state except IDLE.
REQ-017 frame_idx  output  13: index of the frame currently being read or next to be read.

Function
REQ-018 The block SHALL use the states IDLE, WAIT_BANK, CMD, ADDR, DATA and GAP.
REQ-019 IDLE SHALL go to WAIT_BANK on start; start SHALL be ignored in every other state.
REQ-020 WAIT_BANK SHALL hold SPI_CS_N=1 and go to CMD on the first cycle bank_full=0.
REQ-021 On entry to CMD, SPI_CS_N SHALL go to 0 and MOSI SHALL present bit 7 of 8'h03.
REQ-022 CMD SHALL shift out 8 bits and ADDR SHALL shift out 24 bits, MOSI changing one cycle after each falling edge of SPI_clk.
REQ-023 The frame address SHALL be BASE_ADDR + frame_idx*(FRAME_BITS/8), truncated to 24 bits (wraps modulo 2^24).
REQ-024 Each SPI_clk level SHALL last exactly CLK_DIV CLK_40 cycles in CMD, ADDR and DATA, and SPI_clk SHALL be 0 in all other states.
REQ-025 In DATA, SPI_clk_en and video_bank_we SHALL be 1 for exactly the one cycle in which registered SPI_clk changes from 0 to 1, and 0 in every other cycle.
REQ-026 DATA SHALL produce exactly FRAME_BITS strobes and then go to GAP, with SPI_CS_N=1, SPI_clk=0 and frame_done=1 for one cycle.
REQ-027 GAP SHALL keep SPI_CS_N high for 4 cycles, increment frame_idx, and then go to WAIT_BANK.
REQ-028 bank_full SHALL be sampled only in WAIT_BANK; if it asserts during a frame, that frame SHALL still complete.
REQ-029 After frame NUM_FRAMES-1, behaviour SHALL follow REQ-033 and REQ-034.

Reset
REQ-030 On reset, the block SHALL go to IDLE with SPI_CS_N=1, SPI_clk=0, MOSI=0, SPI_clk_en=0, video_bank_we=0, frame_done=0, busy=0, frame_idx=0 and all counters at 0.
REQ-031 Reset in any state, including mid-frame, SHALL take effect on the next edge, with no extra strobe or frame_done.
REQ-032 Reset SHALL take priority over start when both are asserted.

Configuration
REQ-033 With SPI_FRAME_LOOP_EN defined, GAP after the last frame SHALL set frame_idx=0 and continue in WAIT_BANK, so streaming never ends.
REQ-034 Without SPI_FRAME_LOOP_EN, GAP after the last frame SHALL go to IDLE with frame_idx=0, and a new start SHALL be required.

Structure
REQ-035 Package spi_frame_pkg SHALL contain the state enum, CMD_READ=8'h03, CMD_BITS=8, ADDR_BITS=24 and CS_GAP=4.
REQ-036 Sub-module spi_clk_gen SHALL divide CLK_40 by CLK_DIV and provide SPI_clk plus one-cycle rise and fall strobes, enabled by the parent.

Verification
REQ-037 Reset, then start, with bank_full=0 and CLK_DIV=2 -> SPI_CS_N falls, MOSI sends 0x03 then 0x000000, and the first SPI_clk_en appears after 32 SPI_clk periods.
REQ-038 Flash model drives a checkerboard pattern -> exactly 30000 strobes, MISO matches at every strobe, frame_done once, then SPI_CS_N high for 4 cycles.
REQ-039 bank_full=1 for 500 cycles at the end of frame 0 -> no SPI_clk edges during the wait; frame 1 then starts with address 0x000EA6.
REQ-040 Reset asserted after strobe 1000 -> next cycle SPI_CS_N=1, SPI_clk=0, frame_idx=0; no further strobes until the next start.
REQ-041 NUM_FRAMES=2, run with and without SPI_FRAME_LOOP_EN -> with the macro, frame_idx goes 0,1,0 and continues; without it, the block enters IDLE with busy=0 after frame 1.
REQ-042 start pulsed during DATA -> no effect; the strobe count stays 30000.
